// File: rtl/sc1602_text_buffer.sv
// Character source for the SC1602 LCD driver: 32-char frame, draw tracking, shift arbiter.
// Optional double buffering with publish-on-frame-boundary: define SC1602_TEXTBUF_DBUF_EN.
module sc1602_text_buffer #(
    parameter logic [7:0] INIT_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
`ifdef SC1602_TEXTBUF_DBUF_EN
    input  logic       commit,
`endif
    input  logic       shift_valid,
    input  logic       shift_dir,
    output logic       shift_ready,
    input  logic       drv_ready_i,
    input  logic       drv_drawing_i,
    input  logic       drv_en_i,
    input  logic       drv_rs_i,
    output logic [7:0] character_o,
    output logic [2:0] command_o,
    output logic [4:0] pos_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_CMD,
        S_DONE
    } state_t;

    state_t     state;
    logic       drawing_q;
    logic       ready_q;
    logic       en_q;
    logic       pulse_cnt;
    logic [7:0] mem [32];

    logic draw_fall;
    logic ready_rise;
    logic ready_fall;
    logic en_rise;
    logic wr_fire;

    assign draw_fall  = drawing_q & ~drv_drawing_i;
    assign ready_rise = ~ready_q & drv_ready_i;
    assign ready_fall = ready_q & ~drv_ready_i;
    assign en_rise    = ~en_q & drv_en_i;
    assign wr_fire    = wr_valid & wr_ready;

    assign shift_ready = (state == S_IDLE) & drv_ready_i;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drawing_q <= 1'b0;
            ready_q   <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            drawing_q <= drv_drawing_i;
            ready_q   <= drv_ready_i;
            en_q      <= drv_en_i;
        end
    end

    // Frame-done wins over a simultaneous draw advance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pos_o <= 5'd0;
        end else if (ready_rise) begin
            pos_o <= 5'd0;
        end else if (draw_fall) begin
            pos_o <= pos_o + 5'd1;
        end
    end

`ifdef SC1602_TEXTBUF_DBUF_EN
    logic [7:0] back [32];
    logic       pending;
    logic       frame_edge;

    assign frame_edge = ready_rise | (draw_fall & (pos_o == 5'd31));
    assign wr_ready   = ~pending;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending <= 1'b0;
        end else if (pending && frame_edge) begin
            pending <= 1'b0;
        end else if (commit) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) back[i] <= INIT_CHAR;
        end else if (wr_fire) begin
            back[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) mem[i] <= INIT_CHAR;
        end else if (pending && frame_edge) begin
            for (int i = 0; i < 32; i++) mem[i] <= back[i];
        end
    end
`else
    assign wr_ready = 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) mem[i] <= INIT_CHAR;
        end else if (wr_fire) begin
            mem[wr_addr] <= wr_data;
        end
    end
`endif

    // Frozen while drawing so both nibbles come from the same character.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            character_o <= INIT_CHAR;
        end else if (!drv_drawing_i) begin
            character_o <= mem[pos_o];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            command_o <= 3'b000;
            pulse_cnt <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (shift_valid && shift_ready) begin
                        command_o <= {2'b01, shift_dir};
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ready_fall) begin
                        pulse_cnt <= 1'b0;
                        state     <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (en_rise && !drv_rs_i) begin
                        if (pulse_cnt) begin
                            state <= S_DONE;
                        end else begin
                            pulse_cnt <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    command_o <= 3'b000;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sc1602_text_buffer.sv
// Directed testbench for sc1602_text_buffer (either build).
// Drives a simple driver model and checks characters, position and shift commands.
module tb_sc1602_text_buffer;

    logic       clk;
    logic       resetn;
    logic       wr_valid;
    logic       wr_ready;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       commit;
    logic       shift_valid;
    logic       shift_dir;
    logic       shift_ready;
    logic       drv_ready_i;
    logic       drv_drawing_i;
    logic       drv_en_i;
    logic       drv_rs_i;
    logic [7:0] character_o;
    logic [2:0] command_o;
    logic [4:0] pos_o;

    int checks;
    int failures;
    logic [7:0] exp_mem [32];

    sc1602_text_buffer dut (
        .clk          (clk),
        .resetn       (resetn),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
`ifdef SC1602_TEXTBUF_DBUF_EN
        .commit       (commit),
`endif
        .shift_valid  (shift_valid),
        .shift_dir    (shift_dir),
        .shift_ready  (shift_ready),
        .drv_ready_i  (drv_ready_i),
        .drv_drawing_i(drv_drawing_i),
        .drv_en_i     (drv_en_i),
        .drv_rs_i     (drv_rs_i),
        .character_o  (character_o),
        .command_o    (command_o),
        .pos_o        (pos_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [4:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        step(1);
        wr_valid = 1'b0;
    endtask

    task automatic frame_sync();
        drv_ready_i = 1'b1;
        step(2);
        drv_ready_i = 1'b0;
        step(2);
    endtask

    task automatic publish();
`ifdef SC1602_TEXTBUF_DBUF_EN
        commit = 1'b1;
        step(1);
        commit = 1'b0;
`endif
        frame_sync();
    endtask

    task automatic en_pulse(input logic rs);
        drv_rs_i = rs;
        drv_en_i = 1'b1;
        step(2);
        drv_en_i = 1'b0;
        step(1);
        drv_rs_i = 1'b0;
        step(1);
    endtask

    task automatic draw_check(input int n);
        for (int i = 0; i < n; i++) begin
            drv_drawing_i = 1'b1;
            step(2);
            checks++;
            if (pos_o !== 5'(i)) begin
                failures++;
                $display("FAIL draw_pos i=%0d got=%0d exp=%0d", i, pos_o, i);
            end
            checks++;
            if (character_o !== exp_mem[i]) begin
                failures++;
                $display("FAIL draw_char i=%0d got=%h exp=%h", i, character_o, exp_mem[i]);
            end
            drv_drawing_i = 1'b0;
            step(3);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step(3);
        resetn = 1'b1;
        step(1);
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_wr_ready got=%b exp=1", wr_ready);
        end
        checks++;
        if (shift_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_shift_ready got=%b exp=0", shift_ready);
        end
        checks++;
        if (character_o !== 8'h20) begin
            failures++;
            $display("FAIL reset_char got=%h exp=20", character_o);
        end
        checks++;
        if (command_o !== 3'b000) begin
            failures++;
            $display("FAIL reset_cmd got=%b exp=000", command_o);
        end
        checks++;
        if (pos_o !== 5'd0) begin
            failures++;
            $display("FAIL reset_pos got=%0d exp=0", pos_o);
        end
    endtask

    task automatic test_blank_frame();
        draw_check(32);
        checks++;
        if (pos_o !== 5'd0) begin
            failures++;
            $display("FAIL pos_wrap got=%0d exp=0", pos_o);
        end
    endtask

    task automatic test_write();
        host_write(5'd5, 8'h41);
        host_write(5'd16, 8'h42);
        exp_mem[5]  = 8'h41;
        exp_mem[16] = 8'h42;
        publish();
        draw_check(32);
    endtask

    task automatic test_write_while_drawing();
        frame_sync();
        draw_check(3);
        drv_drawing_i = 1'b1;
        step(1);
        host_write(5'd3, 8'h5A);
        step(1);
        checks++;
        if (character_o !== 8'h20) begin
            failures++;
            $display("FAIL frozen_char got=%h exp=20", character_o);
        end
        drv_drawing_i = 1'b0;
        step(3);
        exp_mem[3] = 8'h5A;
        publish();
        draw_check(4);
    endtask

    task automatic test_shift();
        drv_ready_i = 1'b1;
        step(1);
        checks++;
        if (shift_ready !== 1'b1) begin
            failures++;
            $display("FAIL shift_ready_idle got=%b exp=1", shift_ready);
        end
        shift_valid = 1'b1;
        shift_dir   = 1'b1;
        step(1);
        shift_valid = 1'b0;
        shift_dir   = 1'b0;
        checks++;
        if (command_o !== 3'b011) begin
            failures++;
            $display("FAIL shift_req_cmd got=%b exp=011", command_o);
        end
        checks++;
        if (shift_ready !== 1'b0) begin
            failures++;
            $display("FAIL shift_busy_ready got=%b exp=0", shift_ready);
        end
        drv_ready_i = 1'b0;
        step(2);
        en_pulse(1'b1);
        en_pulse(1'b0);
        checks++;
        if (command_o !== 3'b011) begin
            failures++;
            $display("FAIL shift_hold_cmd got=%b exp=011", command_o);
        end
        en_pulse(1'b0);
        step(2);
        checks++;
        if (command_o !== 3'b000) begin
            failures++;
            $display("FAIL shift_done_cmd got=%b exp=000", command_o);
        end
        drv_ready_i = 1'b1;
        step(1);
        checks++;
        if (shift_ready !== 1'b1) begin
            failures++;
            $display("FAIL shift_ready_back got=%b exp=1", shift_ready);
        end
        drv_ready_i = 1'b0;
        step(2);
    endtask

    task automatic test_shift_not_ready();
        drv_ready_i = 1'b0;
        shift_valid = 1'b1;
        shift_dir   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++;
            if (shift_ready !== 1'b0 || command_o !== 3'b000) begin
                failures++;
                $display("FAIL shift_blocked rdy=%b cmd=%b exp rdy=0 cmd=000",
                         shift_ready, command_o);
            end
        end
        shift_valid = 1'b0;
        shift_dir   = 1'b0;
        step(1);
    endtask

    task automatic test_back_to_back();
        drv_ready_i = 1'b1;
        step(1);
        wr_valid    = 1'b1;
        wr_addr     = 5'd0;
        wr_data     = 8'h55;
        shift_valid = 1'b1;
        shift_dir   = 1'b0;
        step(1);
        wr_valid    = 1'b0;
        shift_valid = 1'b0;
        exp_mem[0]  = 8'h55;
        checks++;
        if (command_o !== 3'b010) begin
            failures++;
            $display("FAIL b2b_cmd got=%b exp=010", command_o);
        end
        drv_ready_i = 1'b0;
        step(2);
        en_pulse(1'b0);
        en_pulse(1'b0);
        step(2);
        checks++;
        if (command_o !== 3'b000) begin
            failures++;
            $display("FAIL b2b_done_cmd got=%b exp=000", command_o);
        end
        publish();
        draw_check(1);
    endtask

`ifdef SC1602_TEXTBUF_DBUF_EN
    task automatic test_dbuf();
        frame_sync();
        host_write(5'd0, 8'h31);
        commit = 1'b1;
        step(1);
        commit = 1'b0;
        step(1);
        commit = 1'b1;
        step(1);
        commit = 1'b0;
        draw_check(31);
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL dbuf_pending_wr_ready got=%b exp=0", wr_ready);
        end
        drv_drawing_i = 1'b1;
        step(2);
        drv_drawing_i = 1'b0;
        step(3);
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL dbuf_released_wr_ready got=%b exp=1", wr_ready);
        end
        exp_mem[0] = 8'h31;
        draw_check(1);
    endtask
`endif

    initial begin
        checks        = 0;
        failures      = 0;
        wr_valid      = 1'b0;
        wr_addr       = 5'd0;
        wr_data       = 8'h00;
        commit        = 1'b0;
        shift_valid   = 1'b0;
        shift_dir     = 1'b0;
        drv_ready_i   = 1'b0;
        drv_drawing_i = 1'b0;
        drv_en_i      = 1'b0;
        drv_rs_i      = 1'b0;
        for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
        test_reset();
        test_blank_frame();
        test_write();
        test_write_while_drawing();
        test_shift();
        test_shift_not_ready();
        test_back_to_back();
`ifdef SC1602_TEXTBUF_DBUF_EN
        test_dbuf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
